ov7670_stream_gen: RTL and testbench

Emulates the OV7670 parallel video output: PCLK, VSYNC, HREF and D[7:0] carrying QVGA RGB444 test patterns. It drives the camera-side inputs of the capture path (pixel deserializer → video buffer → VGA) from inside the FPGA or the bench, so capture and display can be brought up without a sensor. It is the transmitting end of the camera pixel interface.

---
 rtl/ov7670_stream_gen.sv | 179 +++++++++++++++++
 tb/tb_ov7670_stream_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ov7670_stream_gen.sv
// OV7670-style parallel video source: PCLK/VSYNC/HREF/D[7:0] carrying RGB444 test patterns.
// Frame timing runs in PCLK ticks. Every framing and pixel output is registered on the falling PCLK edge.
module ov7670_stream_gen #(
    parameter int unsigned H_ACTIVE    = 320,
    parameter int unsigned H_BLANK     = 144,
    parameter int unsigned VSYNC_LINES = 3,
    parameter int unsigned V_BACK      = 17,
    parameter int unsigned V_ACTIVE    = 240,
    parameter int unsigned V_FRONT     = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [11:0] solid_rgb,
    output logic        pclk_o,
    output logic        vsync_o,
    output logic        href_o,
    output logic [7:0]  d_o,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned HREF_TICKS = 2 * H_ACTIVE;
    localparam int unsigned LINE_TICKS = HREF_TICKS + H_BLANK;
    localparam int unsigned BAR_W      = H_ACTIVE / 8;
    localparam int unsigned MAX_VA     = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int unsigned MAX_VB     = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int unsigned MAX_LINES  = (MAX_VA > MAX_VB) ? MAX_VA : MAX_VB;
    localparam int unsigned TW         = $clog2(LINE_TICKS + 1);
    localparam int unsigned LW         = $clog2(MAX_LINES + 1);
    localparam int unsigned XW         = $clog2(H_ACTIVE + 1);
    localparam int unsigned YW         = $clog2(V_ACTIVE + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VSYNC  = 3'd1;
    localparam logic [2:0] S_VBACK  = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_VFRONT = 3'd4;

    logic [2:0]    state, state_n;
    logic [TW-1:0] tick_cnt, tick_n;
    logic [LW-1:0] line_cnt, line_n;
    logic [1:0]    pat_q;
    logic [11:0]   solid_q;

    logic          advance_c;
    logic          load_cfg_c;
    logic          frame_end_c;
    logic          vsync_n, href_n;
    logic [7:0]    d_n;
    logic [XW-1:0] x_n;
    logic [YW-1:0] y_n;
    logic [2:0]    bar_c;
    logic [11:0]   rgb_c;
    int unsigned   phase_lines;

    // State register, position counters and registered video outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            line_cnt   <= '0;
            pat_q      <= '0;
            solid_q    <= '0;
            pclk_o     <= 1'b0;
            vsync_o    <= 1'b0;
            href_o     <= 1'b0;
            d_o        <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            tick_cnt   <= tick_n;
            line_cnt   <= line_n;
            frame_done <= frame_end_c;
            if (load_cfg_c) begin
                pat_q   <= pattern_sel;
                solid_q <= solid_rgb;
            end
            if (state == S_IDLE) begin
                pclk_o <= 1'b0;
                busy   <= enable;
            end else begin
                pclk_o <= ~pclk_o;
                if (frame_end_c && !enable) begin
                    busy <= 1'b0;
                end
            end
            if (advance_c) begin
                vsync_o <= vsync_n;
                href_o  <= href_n;
                d_o     <= d_n;
            end
        end
    end

    // Next position in the frame; outputs are derived from the position being entered
    always_comb begin
        state_n     = state;
        tick_n      = tick_cnt;
        line_n      = line_cnt;
        advance_c   = 1'b0;
        load_cfg_c  = 1'b0;
        frame_end_c = 1'b0;
        phase_lines = VSYNC_LINES;

        case (state)
            S_VBACK:  phase_lines = V_BACK;
            S_ACTIVE: phase_lines = V_ACTIVE;
            S_VFRONT: phase_lines = V_FRONT;
            default:  phase_lines = VSYNC_LINES;
        endcase

        if (state == S_IDLE) begin
            if (enable) begin
                state_n    = S_VSYNC;
                tick_n     = '0;
                line_n     = '0;
                advance_c  = 1'b1;
                load_cfg_c = 1'b1;
            end
        end else if (pclk_o) begin
            advance_c = 1'b1;
            if (tick_cnt == TW'(LINE_TICKS - 1)) begin
                tick_n = '0;
                if (line_cnt == LW'(phase_lines - 1)) begin
                    line_n = '0;
                    case (state)
                        S_VSYNC:  state_n = S_VBACK;
                        S_VBACK:  state_n = S_ACTIVE;
                        S_ACTIVE: state_n = S_VFRONT;
                        default: begin
                            frame_end_c = 1'b1;
                            load_cfg_c  = enable;
                            state_n     = enable ? S_VSYNC : S_IDLE;
                        end
                    endcase
                end else begin
                    line_n = line_cnt + LW'(1);
                end
            end else begin
                tick_n = tick_cnt + TW'(1);
            end
        end
    end

    // Pixel generator for the position being entered
    always_comb begin
        x_n   = XW'(tick_n >> 1);
        y_n   = YW'(line_n);
        bar_c = 3'(32'(x_n) / BAR_W);
        rgb_c = solid_q;
        case (pat_q)
            2'd0: begin
                case (bar_c)
                    3'd0:    rgb_c = 12'hFFF;
                    3'd1:    rgb_c = 12'hFF0;
                    3'd2:    rgb_c = 12'h0FF;
                    3'd3:    rgb_c = 12'h0F0;
                    3'd4:    rgb_c = 12'hF0F;
                    3'd5:    rgb_c = 12'hF00;
                    3'd6:    rgb_c = 12'h00F;
                    default: rgb_c = 12'h000;
                endcase
            end
            2'd1:    rgb_c = 12'(32'(x_n) + 32'(y_n));
            default: rgb_c = solid_q;
        endcase

        vsync_n = (state_n == S_VSYNC);
        href_n  = (state_n == S_ACTIVE) && (32'(tick_n) < HREF_TICKS);
        d_n     = 8'h00;
        if (href_n) begin
            d_n = tick_n[0] ? rgb_c[7:0] : {4'h0, rgb_c[11:8]};
        end
    end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Directed bench for ov7670_stream_gen with a small frame geometry and a behavioural capture receiver.
module tb_ov7670_stream_gen;

    localparam int unsigned HA = 16, HB = 4, VS = 2, VBK = 1, VA = 6, VF = 2;
    localparam int unsigned LINE  = 2 * HA + HB;
    localparam int unsigned FRAME = (VS + VBK + VA + VF) * LINE;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [11:0] solid_rgb;
    logic        pclk_o, vsync_o, href_o, busy, frame_done;
    logic [7:0]  d_o;

    int n_tests = 0;
    int n_fail  = 0;

    ov7670_stream_gen #(
        .H_ACTIVE(HA), .H_BLANK(HB), .VSYNC_LINES(VS),
        .V_BACK(VBK), .V_ACTIVE(VA), .V_FRONT(VF)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
        .solid_rgb(solid_rgb), .pclk_o(pclk_o), .vsync_o(vsync_o),
        .href_o(href_o), .d_o(d_o), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Receiver model: samples on rising pclk_o like the capture deserializer
    logic [7:0] mem [0:3][0:7][0:31];
    int frame_idx = -1, row = 0, col = 0, hlen = 0, glen = 0;
    int frame_rises [0:3];
    int vs_ticks [0:3];
    int href_pulses [0:3];
    int hlen_min = 100000, hlen_max = 0, gap_min = 100000, gap_max = 0;
    int blank_bad = 0;
    logic prev_vs = 1'b0, prev_href = 1'b0;

    initial begin
        for (int i = 0; i < 4; i++) begin
            frame_rises[i] = 0; vs_ticks[i] = 0; href_pulses[i] = 0;
        end
    end

    always @(posedge pclk_o) begin
        if (!rst) begin
            if (vsync_o && !prev_vs) begin
                frame_idx++;
                row = 0;
            end
            if (frame_idx >= 0 && frame_idx < 4) begin
                frame_rises[frame_idx]++;
                if (vsync_o) vs_ticks[frame_idx]++;
            end
            if (href_o) begin
                if (!prev_href) begin
                    if (row > 0) begin
                        if (glen < gap_min) gap_min = glen;
                        if (glen > gap_max) gap_max = glen;
                    end
                    col = 0;
                    hlen = 0;
                    if (frame_idx >= 0 && frame_idx < 4) href_pulses[frame_idx]++;
                end
                if (frame_idx >= 0 && frame_idx < 4 && row < 8 && col < 32)
                    mem[frame_idx][row][col] = d_o;
                col++;
                hlen++;
            end else begin
                if (prev_href) begin
                    if (hlen < hlen_min) hlen_min = hlen;
                    if (hlen > hlen_max) hlen_max = hlen;
                    row++;
                    glen = 0;
                end
                glen++;
                if (d_o != 8'h00) blank_bad++;
            end
            prev_vs   = vsync_o;
            prev_href = href_o;
        end
    end

    // frame_done pulse log with clk-cycle timestamps
    int cyc = 0;
    int fd_n = 0;
    int fd_cyc [0:7];
    always @(posedge clk) begin
        if (!rst && frame_done) begin
            if (fd_n < 8) fd_cyc[fd_n] = cyc;
            fd_n++;
        end
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_px(input int f, input int y, input int x, input logic [7:0] b0, input logic [7:0] b1);
        check($sformatf("px f%0d y%0d x%0d b0", f, y, x), 32'(mem[f][y][2*x]), 32'(b0));
        check($sformatf("px f%0d y%0d x%0d b1", f, y, x), 32'(mem[f][y][2*x+1]), 32'(b1));
    endtask

    task automatic idle_window(input string tag, input int n);
        int highs = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (pclk_o || busy) highs++;
        end
        check(tag, 32'(highs), 32'd0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; pattern_sel = 2'd0; solid_rgb = 12'h123;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {22'd0, pclk_o, vsync_o, href_o, d_o, busy, frame_done}, 32'd0);
        @(negedge clk) rst = 1'b0;
        idle_window("idle pclk/busy", 200);

        // Start: busy and vsync on the next edge, pclk_o rises one clk later
        @(negedge clk) begin enable = 1'b1; pattern_sel = 2'd0; end
        @(posedge clk);
        #1;
        check("start busy/vsync/pclk", {29'd0, busy, vsync_o, pclk_o}, 32'b110);
        @(posedge clk);
        #1;
        check("start pclk rises", 32'(pclk_o), 32'd1);

        repeat (400) @(posedge clk);
        @(negedge clk) begin pattern_sel = 2'd2; solid_rgb = 12'hA5C; end
        repeat (792) @(posedge clk);
        @(negedge clk) pattern_sel = 2'd1;
        repeat (792) @(posedge clk);
        @(negedge clk) enable = 1'b0;

        for (int i = 0; i < 2000 && busy; i++) @(posedge clk);
        #1;
        check("busy drops after last frame", 32'(busy), 32'd0);
        check("stopped pclk/vsync/href", {29'd0, pclk_o, vsync_o, href_o}, 32'd0);

        check("frames captured", 32'(frame_idx), 32'd2);
        check("frame_done count", 32'(fd_n), 32'd3);
        check("frame_done interval 0-1", 32'(fd_cyc[1] - fd_cyc[0]), 32'(2 * FRAME));
        check("frame_done interval 1-2", 32'(fd_cyc[2] - fd_cyc[1]), 32'(2 * FRAME));
        check("frame0 ticks", 32'(frame_rises[0]), 32'(FRAME));
        check("frame2 ticks", 32'(frame_rises[2]), 32'(FRAME));
        check("vsync ticks", 32'(vs_ticks[0]), 32'(VS * LINE));
        check("href pulses f0", 32'(href_pulses[0]), 32'(VA));
        check("href pulses f2", 32'(href_pulses[2]), 32'(VA));
        check("href len min", 32'(hlen_min), 32'(2 * HA));
        check("href len max", 32'(hlen_max), 32'(2 * HA));
        check("href gap min", 32'(gap_min), 32'(HB));
        check("href gap max", 32'(gap_max), 32'(HB));
        check("d nonzero in blank", 32'(blank_bad), 32'd0);

        // Frame 0: colour bars, 2-pixel bars
        check_px(0, 0, 0,  8'h0F, 8'hFF);
        check_px(0, 0, 2,  8'h0F, 8'hF0);
        check_px(0, 3, 4,  8'h00, 8'hFF);
        check_px(0, 0, 10, 8'h0F, 8'h00);
        check_px(0, 0, 15, 8'h00, 8'h00);
        // Frame 1: solid latched at frame start
        check_px(1, 0, 0,  8'h0A, 8'h5C);
        check_px(1, 2, 7,  8'h0A, 8'h5C);
        // Frame 2: ramp (x+y)
        check_px(2, 0, 1,  8'h00, 8'h01);
        check_px(2, 5, 10, 8'h00, 8'h0F);
        check_px(2, 5, 15, 8'h00, 8'h14);

        idle_window("idle after stop", 100);

        // Asynchronous reset in the middle of an active line
        @(negedge clk) enable = 1'b1;
        for (int i = 0; i < 2000 && !href_o; i++) @(posedge clk);
        #1;
        check("href reached before reset", 32'(href_o), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid-frame reset outputs", {22'd0, pclk_o, vsync_o, href_o, d_o, busy, frame_done}, 32'd0);
        enable = 1'b0;
        @(negedge clk) rst = 1'b0;
        idle_window("idle after reset", 1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
